// File: rtl/layer_stream_scheduler_if.sv
// layer_stream_scheduler_if: source, chain and result signals of the layer scheduler.
interface layer_stream_scheduler_if #(
  parameter int BITWIDTH          = 8,
  parameter int INPUT_VECTOR_SIZE = 3,
  parameter int NUM_CELLS         = 4
);
  localparam int WI = $clog2(INPUT_VECTOR_SIZE);
  localparam int RI = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  typedef struct packed {
    logic                isValid;
    logic                isFirst;
    logic                isLast;
    logic                isResult;
    logic [WI-1:0]       wIndex;
    logic [BITWIDTH-1:0] data;
  } cell_t;
  logic                i_start;
  logic [15:0]         i_num_vectors;
  logic                i_in_valid;
  logic [BITWIDTH-1:0] i_in_data;
  logic                o_in_ready;
  cell_t               o_cell_out;
  cell_t               i_chain_in;
  logic                o_res_valid;
  logic [BITWIDTH-1:0] o_res_data;
  logic [RI-1:0]       o_res_index;
  logic                o_busy;
  logic                o_done;
  logic                o_err_missing;
  modport master (
    output i_start, i_num_vectors, i_in_valid, i_in_data, i_chain_in,
    input  o_in_ready, o_cell_out, o_res_valid, o_res_data, o_res_index, o_busy, o_done, o_err_missing
  );
  modport slave (
    input  i_start, i_num_vectors, i_in_valid, i_in_data, i_chain_in,
    output o_in_ready, o_cell_out, o_res_valid, o_res_data, o_res_index, o_busy, o_done, o_err_missing
  );
endinterface

// File: rtl/layer_stream_scheduler.sv
// layer_stream_scheduler: frames input vectors into a cell chain, inserts drain bubbles, collects results.
module layer_stream_scheduler #(
  parameter int BITWIDTH          = 8,
  parameter int INPUT_VECTOR_SIZE = 3,
  parameter int NUM_CELLS         = 4,
  parameter int DRAIN_CYCLES      = 2 * NUM_CELLS,
  parameter int TIMEOUT_CYCLES    = 4 * NUM_CELLS + 8
) (
  input logic                    clock,
  input logic                    reset_n,
  layer_stream_scheduler_if.slave sif
);
  localparam int WI = $clog2(INPUT_VECTOR_SIZE);
  localparam int RI = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(NUM_CELLS + 1);
  typedef struct packed {
    logic                isValid;
    logic                isFirst;
    logic                isLast;
    logic                isResult;
    logic [WI-1:0]       wIndex;
    logic [BITWIDTH-1:0] data;
  } cell_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;
  state_t              r_state, w_next;
  logic [15:0]         r_num, r_vec;
  logic [WI-1:0]       r_elem;
  logic [DW-1:0]       r_drain;
  logic [GW-1:0]       r_got;
  cell_t               r_cell;
  logic                r_res_valid, r_err;
  logic [BITWIDTH-1:0] r_res_data;
  logic [RI-1:0]       r_res_idx, r_res_cnt;
  logic w_start, w_acc, w_last, w_hit, w_got_all, w_timeout, w_drain_end, w_more;
  assign w_start     = (r_state == IDLE) && sif.i_start;
  assign w_acc       = (r_state == STREAM) && sif.i_in_valid;
  assign w_last      = w_acc && (r_elem == WI'(INPUT_VECTOR_SIZE - 1));
  assign w_hit       = sif.i_chain_in.isValid && sif.i_chain_in.isResult;
  assign w_got_all   = r_got == GW'(NUM_CELLS);
  assign w_timeout   = (r_state == DRAIN) && (r_drain == DW'(TIMEOUT_CYCLES - 1)) && !w_got_all;
  assign w_drain_end = ((r_state == DRAIN) && (r_drain >= DW'(DRAIN_CYCLES - 1)) && w_got_all) || w_timeout;
  assign w_more      = ({1'b0, r_vec} + 17'd1) < {1'b0, r_num};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? ((sif.i_num_vectors == 16'd0) ? FINISH : STREAM) : IDLE;
      STREAM:  w_next = w_last ? DRAIN : STREAM;
      DRAIN:   w_next = w_drain_end ? (w_more ? STREAM : FINISH) : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_num       <= '0;
      r_vec       <= '0;
      r_elem      <= '0;
      r_drain     <= '0;
      r_got       <= '0;
      r_cell      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_res_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_start) begin
        r_num  <= sif.i_num_vectors;
        r_vec  <= '0;
        r_elem <= '0;
        r_err  <= 1'b0;
      end
      r_cell.isValid  <= w_acc;
      r_cell.isFirst  <= w_acc && (r_elem == '0);
      r_cell.isLast   <= w_last;
      r_cell.isResult <= 1'b0;
      if (w_acc) begin
        r_cell.wIndex <= r_elem;
        r_cell.data   <= sif.i_in_data;
        r_elem        <= w_last ? '0 : r_elem + 1'b1;
      end
      r_drain <= ((r_state == DRAIN) && !w_drain_end) ? r_drain + 1'b1 : '0;
      r_got   <= (r_state != DRAIN) ? '0 : (w_hit && !w_got_all) ? r_got + 1'b1 : r_got;
      if (w_drain_end) r_vec <= r_vec + 16'd1;
      if (w_timeout)   r_err <= 1'b1;
      // Results are reported in every state; the index just keeps wrapping.
      r_res_valid <= w_hit;
      if (w_hit) begin
        r_res_data <= sif.i_chain_in.data;
        r_res_idx  <= r_res_cnt;
        r_res_cnt  <= (r_res_cnt == RI'(NUM_CELLS - 1)) ? '0 : r_res_cnt + 1'b1;
      end
    end
  end
  assign sif.o_in_ready    = r_state == STREAM;
  assign sif.o_busy        = (r_state == STREAM) || (r_state == DRAIN);
  assign sif.o_done        = r_state == FINISH;
  assign sif.o_cell_out    = r_cell;
  assign sif.o_res_valid   = r_res_valid;
  assign sif.o_res_data    = r_res_data;
  assign sif.o_res_index   = r_res_idx;
  assign sif.o_err_missing = r_err;
endmodule
